// File: rtl/qar_dmem_arbiter.sv
// Round-robin arbiter for the shared qar_core data-memory port; one transaction in flight.
// Latency: request seen in IDLE -> mem_valid next cycle -> req_ready the cycle after mem_ready.
// Backpressure: mem_ready low holds BUSY with registered fields stable; masters hold until req_ready.
// Optional: QAR_ARB_LOCK_EN adds req_lock to re-grant the same master for atomic sequences.
module qar_dmem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
`ifdef QAR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic                          mem_valid,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [1:0]                    grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [1:0]              last_grant_q;
    logic [1:0]              grant_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    // Valid vector padded to 4 bits so a 2-bit index is always in range
    logic [3:0]              valid4;
    logic                    any_valid;
    logic [1:0]              cand;
    logic [1:0]              rr_sel;
    logic                    rr_found;
    logic                    lock_hit;
    logic [1:0]              sel;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [3:0]              ready4;

    assign valid4    = 4'(req_valid);
    assign any_valid = |req_valid;

    // Round-robin search: first valid master after last_grant, wrapping at NUM_REQ
    always_comb begin
        cand     = 2'd0;
        rr_sel   = last_grant_q;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((int'(last_grant_q) + k) % NUM_REQ);
            if (!rr_found && valid4[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

`ifdef QAR_ARB_LOCK_EN
    logic       lock_q;
    logic [3:0] lock4;

    assign lock4    = 4'(req_lock);
    // A held lock only wins if its owner is requesting again in this IDLE cycle
    assign lock_hit = lock_q && valid4[grant_q];

    // Lock is sampled in RESP and consumed (or dropped) in the following IDLE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (state_q == S_RESP) begin
            lock_q <= lock4[grant_q];
        end else if (state_q == S_IDLE) begin
            lock_q <= 1'b0;
        end
    end
`else
    assign lock_hit = 1'b0;
`endif

    assign sel = lock_hit ? grant_q : rr_sel;

    // Mux the winning master's request fields
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (2'(i) == sel) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> BUSY -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_valid) state_d = S_BUSY;
            S_BUSY:  if (mem_ready) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        mem_valid = (state_q == S_BUSY);
        busy      = (state_q != S_IDLE);
        ready4    = 4'b0001 << grant_q;
        req_ready = '0;
        if (state_q == S_RESP) begin
            req_ready = ready4[NUM_REQ-1:0];
        end
    end

    // Latch the granted request in IDLE and capture read data at the memory handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 2'd0;
            last_grant_q <= 2'(NUM_REQ - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (state_q == S_IDLE && any_valid) begin
                grant_q <= sel;
                if (!lock_hit) begin
                    last_grant_q <= sel;
                end
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == S_BUSY && mem_ready) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign req_rdata = rdata_q;
    assign grant_id  = grant_q;

endmodule
